// File: rtl/serial_frame_rx.sv
// Asynchronous serial frame receiver: start bit, 8 data bits LSB first, optional even parity, stop bit.
// A bad stop bit flags a framing error and parks the receiver until the line returns high.
module serial_frame_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       dataIn,
  output logic [7:0] dataByte,
  output logic       dataValid,
  output logic       parityErr,
  output logic       frameErr,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_TICK = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rxState_t;

  rxState_t      state;
  rxState_t      nextState;
  logic          syncA;
  logic          line;
  logic [CW-1:0] bitTimer;
  logic [2:0]    bitIndex;
  logic [7:0]    shiftReg;
  logic          parityFlag;
  logic          timerClear;
  logic          shiftEn;
  logic          parityLoad;
  logic          validLoad;
  logic          frameLoad;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      syncA <= 1'b1;
      line  <= 1'b1;
    end else begin
      syncA <= dataIn;
      line  <= syncA;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and datapath strobes; every sample point is a bit-timer match.
  always_comb begin
    nextState  = state;
    shiftEn    = 1'b0;
    parityLoad = 1'b0;
    validLoad  = 1'b0;
    frameLoad  = 1'b0;
    case (state)
      IDLE: begin
        if (!line) nextState = START;
      end
      START: begin
        if (bitTimer == HALF_TICK) nextState = line ? IDLE : DATA;
      end
      DATA: begin
        if (bitTimer == LAST_TICK) begin
          shiftEn = 1'b1;
          if (bitIndex == 3'd7) nextState = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bitTimer == LAST_TICK) begin
          parityLoad = 1'b1;
          nextState  = STOP;
        end
      end
      STOP: begin
        if (bitTimer == LAST_TICK) begin
          if (line) begin
            validLoad = 1'b1;
            nextState = IDLE;
          end else begin
            frameLoad = 1'b1;
            nextState = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (line) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    timerClear = (nextState != state) || shiftEn || (state == IDLE) || (state == WAIT_HIGH);
    busy       = (state != IDLE);
  end

  // Bit timer restarts on every state entry and after each data sample.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bitTimer <= '0;
    end else if (timerClear) begin
      bitTimer <= '0;
    end else begin
      bitTimer <= bitTimer + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bitIndex <= '0;
      shiftReg <= '0;
    end else begin
      if (state != DATA) begin
        bitIndex <= '0;
      end else if (shiftEn) begin
        bitIndex <= bitIndex + 3'd1;
      end
      if (shiftEn) shiftReg <= {line, shiftReg[7:1]};
    end
  end

  // Parity flag is 1 when data bits plus received parity bit are odd.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      parityFlag <= 1'b0;
    end else if (parityLoad) begin
      parityFlag <= (^shiftReg) ^ line;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      dataByte  <= 8'h00;
      dataValid <= 1'b0;
      parityErr <= 1'b0;
      frameErr  <= 1'b0;
    end else begin
      dataValid <= validLoad;
      frameErr  <= frameLoad;
      if (validLoad) begin
        dataByte  <= shiftReg;
        parityErr <= (PARITY_EN != 0) ? parityFlag : 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: good frames, parity and framing errors, glitch reject,
// back-to-back frames and mid-frame reset, all against hand-computed expectations.
module tb_serial_frame_rx;

  localparam int CLKS = 16;

  logic       clk;
  logic       resetN;
  logic       dataIn;
  logic [7:0] dataByte;
  logic       dataValid;
  logic       parityErr;
  logic       frameErr;
  logic       busy;

  int checks;
  int errors;
  int cycleCount;
  int startCycle;
  int validCount;
  int frameCount;
  int overlapCount;
  int validBytes[16];
  int validParity[16];
  int validCycles[16];
  int baseValid;

  serial_frame_rx #(.CLKS_PER_BIT(CLKS), .PARITY_EN(1)) dut (
    .clk      (clk),
    .resetN   (resetN),
    .dataIn   (dataIn),
    .dataByte (dataByte),
    .dataValid(dataValid),
    .parityErr(parityErr),
    .frameErr (frameErr),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Output pulses are logged on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (dataValid) begin
      if (validCount < 16) begin
        validBytes[validCount]  <= int'(dataByte);
        validParity[validCount] <= int'(parityErr);
        validCycles[validCount] <= cycleCount;
      end
      validCount <= validCount + 1;
    end
    if (frameErr) frameCount <= frameCount + 1;
    if (dataValid && frameErr) overlapCount <= overlapCount + 1;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic driveBit(input logic b);
    dataIn = b;
    repeat (CLKS) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic par, input logic stop);
    startCycle = cycleCount;
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(b[i]);
    driveBit(par);
    driveBit(stop);
  endtask

  task automatic idleCycles(input int n);
    dataIn = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    cycleCount   = 0;
    validCount   = 0;
    frameCount   = 0;
    overlapCount = 0;
    resetN       = 1'b0;
    dataIn       = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetDataByte", int'(dataByte), 0);
    checkOutput("resetDataValid", int'(dataValid), 0);
    checkOutput("resetParityErr", int'(parityErr), 0);
    checkOutput("resetFrameErr", int'(frameErr), 0);
    checkOutput("resetBusy", int'(busy), 0);
    @(posedge clk);
    #1 resetN = 1'b1;
    idleCycles(5);

    // 0xA5: four ones, even parity bit 0
    applyStimulus(8'hA5, 1'b0, 1'b1);
    idleCycles(20);
    checkOutput("a5Count", validCount, 1);
    checkOutput("a5Byte", validBytes[0], 'hA5);
    checkOutput("a5Parity", validParity[0], 0);
    checkOutput("a5Latency", validCycles[0] - startCycle, 171);
    checkOutput("a5Hold", int'(dataByte), 'hA5);
    checkOutput("a5BusyIdle", int'(busy), 0);

    // 0x3C: four ones, parity bit 1 is wrong
    applyStimulus(8'h3C, 1'b1, 1'b1);
    idleCycles(20);
    checkOutput("3cCount", validCount, 2);
    checkOutput("3cByte", validBytes[1], 'h3C);
    checkOutput("3cParity", validParity[1], 1);

    // 0x5A with a low stop bit, then 40 more low cycles
    applyStimulus(8'h5A, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("breakBusy", int'(busy), 1);
    checkOutput("breakFrameCount", frameCount, 1);
    repeat (20) @(posedge clk);
    #1 dataIn = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("breakBusyHeld", int'(busy), 1);
    @(negedge clk);
    checkOutput("breakBusyReleased", int'(busy), 0);
    idleCycles(10);
    checkOutput("breakNoValid", validCount, 2);
    checkOutput("breakByteKept", int'(dataByte), 'h3C);
    checkOutput("breakParityKept", int'(parityErr), 1);

    // 4-cycle glitch on an idle line
    dataIn = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idleCycles(30);
    checkOutput("glitchBusy", int'(busy), 0);
    checkOutput("glitchNoValid", validCount, 2);
    checkOutput("glitchNoFrame", frameCount, 1);

    // Back-to-back 0x01 (parity 1) and 0xFF (parity 0)
    applyStimulus(8'h01, 1'b1, 1'b1);
    applyStimulus(8'hFF, 1'b0, 1'b1);
    idleCycles(20);
    checkOutput("b2bCount", validCount, 4);
    checkOutput("b2bByte0", validBytes[2], 'h01);
    checkOutput("b2bByte1", validBytes[3], 'hFF);
    checkOutput("b2bParity0", validParity[2], 0);
    checkOutput("b2bParity1", validParity[3], 0);
    checkOutput("b2bSpacing", validCycles[3] - validCycles[2], 11 * CLKS);

    // Reset pulse in the middle of data bit 4
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(i[0]);
    dataIn = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("preResetBusy", int'(busy), 1);
    resetN = 1'b0;
    #1;
    checkOutput("midResetDataByte", int'(dataByte), 0);
    checkOutput("midResetDataValid", int'(dataValid), 0);
    checkOutput("midResetParityErr", int'(parityErr), 0);
    checkOutput("midResetFrameErr", int'(frameErr), 0);
    checkOutput("midResetBusy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;
    idleCycles(10);
    baseValid = validCount;
    checkOutput("postResetIdle", int'(busy), 0);
    applyStimulus(8'h81, 1'b0, 1'b1);
    idleCycles(20);
    checkOutput("postResetCount", validCount - baseValid, 1);
    checkOutput("postResetByte", validBytes[4], 'h81);
    checkOutput("postResetParity", validParity[4], 0);
    checkOutput("noOverlap", overlapCount, 0);
    checkOutput("totalFrameErr", frameCount, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 4..1024.
REQ-002 Parameter PARITY_EN, default 1; 1 = even parity bit present, 0 = no parity bit.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 resetN  input  1  asynchronous, active-low reset.
REQ-005 dataIn  input  1  asynchronous serial line (the dataOut stream of the adjacent stage); idles high.
REQ-006 dataByte  output  8  last received payload, LSB received first.
REQ-007 dataValid  output  1  one-cycle pulse; dataByte is valid in that cycle.
REQ-008 parityErr  output  1  qualifies dataValid; 1 = parity mismatch.
REQ-009 frameErr  output  1  one-cycle pulse on a bad stop bit.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 dataIn shall pass through a 2-flop synchronizer (reset value 1) before any use; "line" below means the synchronized value.
REQ-012 The FSM shall have exactly six states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-013 A single bit-timer counter shall be sized to hold CLKS_PER_BIT-1 and cleared on every state entry.
REQ-014 IDLE: line=0 -> START; otherwise remain in IDLE.
REQ-015 START: sample when the counter reaches CLKS_PER_BIT/2-1; line=0 -> DATA with counter cleared; line=1 -> IDLE (glitch reject, no output activity).
REQ-016 DATA: sample every CLKS_PER_BIT cycles; each sample shifts into bit [7] of a shift register that shifts right; after the 8th sample go to PARITY if PARITY_EN=1, otherwise STOP.
REQ-017 PARITY: sample after CLKS_PER_BIT cycles and store (XOR of the 8 data bits) XOR (sampled bit) as a parity-error flag; then go to STOP.
REQ-018 STOP: sample after CLKS_PER_BIT cycles.
REQ-019 STOP, line=1: on the next edge load dataByte from the shift register, pulse dataValid for 1 cycle, drive parityErr to the stored flag (0 when PARITY_EN=0), and go to IDLE.
REQ-020 STOP, line=0: on the next edge pulse frameErr for 1 cycle, leave dataByte unchanged, do not assert dataValid, and go to WAIT_HIGH.
REQ-021 WAIT_HIGH: remain there while line=0 (break condition); go to IDLE on the first cycle line=1.
REQ-022 dataByte and parityErr shall hold their values until the next dataValid.
REQ-023 A new start bit shall be accepted in IDLE on the cycle after dataValid, so back-to-back frames are received with no gap.
REQ-024 Latency: dataValid asserts 1 cycle after the mid-stop-bit sample, plus the 2-cycle synchronizer delay.
REQ-025 dataValid and frameErr shall never assert in the same cycle.

Reset
REQ-026 When resetN=0, the block shall asynchronously force state=IDLE, counter=0, shift register=0, synchronizer flops=1, dataByte=0x00, dataValid=0, parityErr=0, frameErr=0, busy=0.
REQ-027 Reset released mid-frame shall discard the partial frame; reception shall resume only on the next falling edge seen in IDLE.
REQ-028 Reset deassertion shall be taken synchronously to clk by the surrounding logic; the block does not resynchronize resetN.

Verification
REQ-029 CLKS_PER_BIT=16, PARITY_EN=1, frame 0xA5 with parity 0 and stop 1 -> one dataValid pulse, dataByte=0xA5, parityErr=0.
REQ-030 Frame 0x3C sent with parity bit 1 -> dataValid pulse, dataByte=0x3C, parityErr=1.
REQ-031 Frame 0x5A with stop bit 0, line held low 40 cycles, then high -> frameErr pulse, no dataValid, dataByte keeps its previous value, busy stays high until 1 cycle after the line returns high.
REQ-032 A 4-cycle low glitch on an idle line -> state returns to IDLE, no output pulse.
REQ-033 Frames 0x01 and 0xFF sent back-to-back -> two dataValid pulses exactly 11*16 cycles apart, with the correct bytes.
REQ-034 resetN pulsed low during DATA bit 4 -> all outputs 0 immediately, and the next full frame 0x81 is received correctly.
